// File: rtl/stage_3_if.sv
// stage_3_if: bundles the stage_2 -> stage_3 handshake, the normalized
// feedback values returned to stage_2, and the pre-carry byte stream.
//
// Signals:
//   in_valid / in_ready    upstream handshake, accept = in_valid & in_ready
//   range, low             un-normalized range/low from stage_2
//   out_valid              one-cycle pulse when the normalized values update
//   out_range, out_low     normalized range/low fed back to stage_2
//   cnt_out                signed bit counter (-9..-1)
//   byte_valid/byte_ready  byte stream handshake, pop = byte_valid & byte_ready
//   byte_out               head of the byte FIFO (carry bit included)
//
// Modports:
//   master  the environment side (drives inputs, consumes bytes)
//   slave   the stage_3 block itself
interface stage_3_if #(
    parameter int RANGE_WIDTH = 16,
    parameter int LOW_WIDTH   = 24,
    parameter int OUT_WIDTH   = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [RANGE_WIDTH-1:0] range;
    logic [LOW_WIDTH-1:0]   low;
    logic                   out_valid;
    logic [RANGE_WIDTH-1:0] out_range;
    logic [LOW_WIDTH-1:0]   out_low;
    logic signed [4:0]      cnt_out;
    logic                   byte_valid;
    logic                   byte_ready;
    logic [OUT_WIDTH-1:0]   byte_out;

    modport master (
        output in_valid,
        output range,
        output low,
        output byte_ready,
        input  in_ready,
        input  out_valid,
        input  out_range,
        input  out_low,
        input  cnt_out,
        input  byte_valid,
        input  byte_out
    );

    modport slave (
        input  in_valid,
        input  range,
        input  low,
        input  byte_ready,
        output in_ready,
        output out_valid,
        output out_range,
        output out_low,
        output cnt_out,
        output byte_valid,
        output byte_out
    );
endinterface

// File: rtl/stage_3.sv
// stage_3: renormalization stage of the arithmetic coder.
//
// For each accepted (range, low) pair the block counts the leading zeros d
// of range, shifts range and low left by d, and emits zero, one or two
// pre-carry bytes taken from the top of low into a small byte FIFO. The
// signed bit counter cnt tracks how many bits of low are still pending
// before the next byte boundary.
//
// Ports:
//   clk_stage_3    single clock, all state on its rising edge
//   reset_stage_3  asynchronous, active-low reset
//   bus            stage_3_if.slave (input handshake, normalized outputs,
//                  byte FIFO output handshake)
//   byte_count     (only with STAGE_3_BYTE_COUNT_EN) 32-bit count of bytes
//                  popped since reset, wraps at 2^32
//
// Configuration macro: STAGE_3_BYTE_COUNT_EN adds the byte_count output.
module stage_3 #(
    parameter int RANGE_WIDTH = 16,
    parameter int LOW_WIDTH   = 24,
    parameter int D_SIZE      = 4,
    parameter int OUT_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk_stage_3,
    input  logic        reset_stage_3,
    stage_3_if.slave    bus
`ifdef STAGE_3_BYTE_COUNT_EN
    ,
    output logic [31:0] byte_count
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    // cnt starts at -9: nine bits of low must be shifted in before the first
    // byte boundary is reached.
    localparam logic signed [4:0] CNT_RESET = -5'sd9;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Leading-zero count; an all-zero range yields 0.
    function automatic logic [D_SIZE-1:0] lead_zeros(input logic [RANGE_WIDTH-1:0] v);
        logic [D_SIZE-1:0] n;
        n = '0;
        for (int i = 0; i < RANGE_WIDTH; i++) begin
            if (v[i]) begin
                n = D_SIZE'(RANGE_WIDTH - 1 - i);
            end
        end
        return n;
    endfunction

    // Circular pointer increment, correct for non power-of-two depths too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic signed [4:0]      cnt;
    logic [RANGE_WIDTH-1:0] out_range_q;
    logic [LOW_WIDTH-1:0]   out_low_q;
    logic                   out_valid_q;

    logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [OCC_W-1:0]       occupancy;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic accept;
    logic pop;
    logic in_ready_int;
    logic byte_valid_int;

    // Every transaction may push up to two bytes, so the block only accepts
    // while at least two entries are free. This depends on registered
    // occupancy only, so a pop in the same cycle never creates a comb path
    // from byte_ready to in_ready.
    assign in_ready_int   = (occupancy <= OCC_W'(FIFO_DEPTH - 2));
    assign byte_valid_int = (occupancy != '0);
    assign accept         = bus.in_valid & in_ready_int;
    assign pop            = byte_valid_int & bus.byte_ready;

    // ------------------------------------------------------------------
    // Normalization datapath
    // ------------------------------------------------------------------
    logic [D_SIZE-1:0]      d;
    logic signed [4:0]      s;
    logic [4:0]             c;
    logic [4:0]             c8;
    logic [LOW_WIDTH-1:0]   mask_c;
    logic [LOW_WIDTH-1:0]   mask_c8;
    logic [LOW_WIDTH-1:0]   l_sel;
    logic signed [4:0]      cnt_next;
    logic [1:0]             push_cnt;
    logic [OUT_WIDTH-1:0]   byte0;
    logic [OUT_WIDTH-1:0]   byte1;

    assign d = lead_zeros(bus.range);
    assign s = cnt + $signed({1'b0, d});

    // c = cnt + 16 is the bit position of the pending byte boundary inside
    // low; cnt is in -9..-1 so c stays in 7..15. Unsigned 5-bit arithmetic
    // gives the right result modulo 32. c8 is only meaningful when s >= 8,
    // which requires cnt >= -7, so it is never negative where it is used.
    assign c       = $unsigned(cnt) + 5'd16;
    assign c8      = c - 5'd8;
    assign mask_c  = (LOW_WIDTH'(1) << c) - LOW_WIDTH'(1);
    assign mask_c8 = (LOW_WIDTH'(1) << c8) - LOW_WIDTH'(1);

    // Select how many bytes leave low this transaction and what remains.
    always_comb begin
        push_cnt = 2'd0;
        l_sel    = bus.low;
        cnt_next = s;
        byte0    = OUT_WIDTH'(bus.low >> c);
        byte1    = OUT_WIDTH'((bus.low & mask_c) >> c8);
        if (s < 0) begin
            push_cnt = 2'd0;
            l_sel    = bus.low;
            cnt_next = s;
        end else if (s < 5'sd8) begin
            push_cnt = 2'd1;
            l_sel    = bus.low & mask_c;
            cnt_next = s - 5'sd8;
        end else begin
            push_cnt = 2'd2;
            l_sel    = bus.low & mask_c8;
            cnt_next = s - 5'sd8 - 5'sd8;
        end
    end

    // ------------------------------------------------------------------
    // Normalized output registers and bit counter
    // ------------------------------------------------------------------

    // Outputs only move on an accepted transaction; out_valid pulses for the
    // single cycle following acceptance.
    always_ff @(posedge clk_stage_3 or negedge reset_stage_3) begin
        if (!reset_stage_3) begin
            cnt         <= CNT_RESET;
            out_range_q <= {1'b1, {(RANGE_WIDTH-1){1'b0}}};
            out_low_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                cnt         <= cnt_next;
                out_range_q <= bus.range << d;
                out_low_q   <= l_sel << d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [PTR_W-1:0] wr_ptr_p2;
    logic [1:0]       push_now;

    assign wr_ptr_p1 = ptr_inc(wr_ptr);
    assign wr_ptr_p2 = ptr_inc(wr_ptr_p1);
    assign push_now  = accept ? push_cnt : 2'd0;

    // Storage: the first byte always lands at wr_ptr, the second (if any)
    // at the following slot, preserving push order.
    always_ff @(posedge clk_stage_3 or negedge reset_stage_3) begin
        if (!reset_stage_3) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_now != 2'd0) begin
                mem[wr_ptr] <= byte0;
            end
            if (push_now == 2'd2) begin
                mem[wr_ptr_p1] <= byte1;
            end
        end
    end

    // Pointers and occupancy; a simultaneous pop and push both take effect.
    always_ff @(posedge clk_stage_3 or negedge reset_stage_3) begin
        if (!reset_stage_3) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            case (push_now)
                2'd1:    wr_ptr <= wr_ptr_p1;
                2'd2:    wr_ptr <= wr_ptr_p2;
                default: wr_ptr <= wr_ptr;
            endcase
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occupancy <= occupancy + OCC_W'(push_now) - OCC_W'(pop);
        end
    end

`ifdef STAGE_3_BYTE_COUNT_EN
    // Running count of consumed bytes, free-running modulo 2^32.
    always_ff @(posedge clk_stage_3 or negedge reset_stage_3) begin
        if (!reset_stage_3) begin
            byte_count <= '0;
        end else if (pop) begin
            byte_count <= byte_count + 32'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------

    // byte_out is forced to zero when empty so stale entries never show.
    assign bus.in_ready   = in_ready_int;
    assign bus.byte_valid = byte_valid_int;
    assign bus.byte_out   = byte_valid_int ? mem[rd_ptr] : '0;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_range  = out_range_q;
    assign bus.out_low    = out_low_q;
    assign bus.cnt_out    = cnt;

endmodule

// File: tb/tb_stage_3.sv
// tb_stage_3: directed self-checking bench for stage_3.
//
// Drives hand-picked (range, low) transactions through the slave interface
// and compares normalized outputs, the bit counter and the byte stream
// against hand-computed values. Honours STAGE_3_BYTE_COUNT_EN.
module tb_stage_3;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef STAGE_3_BYTE_COUNT_EN
    logic [31:0] byte_count;
`endif

    stage_3_if bus ();

    stage_3 dut (
        .clk_stage_3   (clk),
        .reset_stage_3 (rst_n),
        .bus           (bus)
`ifdef STAGE_3_BYTE_COUNT_EN
        ,
        .byte_count    (byte_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one transaction for a single clock; returns #1 after the edge.
    task automatic applyStimulus(input logic [15:0] r, input logic [23:0] l);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.range    = r;
        bus.low      = l;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic doReset();
        bus.in_valid   = 1'b0;
        bus.byte_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] cnt_val();
        return {27'd0, bus.cnt_out};
    endfunction

    logic [15:0] drain_exp [4];

    initial begin
        bus.in_valid   = 1'b0;
        bus.range      = '0;
        bus.low        = '0;
        bus.byte_ready = 1'b0;
        rst_n          = 1'b1;
        #1 rst_n = 1'b0;
        #1;

        // Reset state, checked while reset is held
        checkOutput("rst_out_range",  32'(bus.out_range),  32'h8000);
        checkOutput("rst_out_low",    32'(bus.out_low),    32'h0);
        checkOutput("rst_out_valid",  32'(bus.out_valid),  32'h0);
        checkOutput("rst_cnt",        cnt_val(),           32'h17);
        checkOutput("rst_byte_valid", 32'(bus.byte_valid), 32'h0);
        checkOutput("rst_in_ready",   32'(bus.in_ready),   32'h1);
        checkOutput("rst_byte_out",   32'(bus.byte_out),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Already normalized range: no shift, no byte
        applyStimulus(16'h8000, 24'h000100);
        checkOutput("t1_out_valid",  32'(bus.out_valid),  32'h1);
        checkOutput("t1_out_range",  32'(bus.out_range),  32'h8000);
        checkOutput("t1_out_low",    32'(bus.out_low),    32'h000100);
        checkOutput("t1_cnt",        cnt_val(),           32'h17);
        checkOutput("t1_byte_valid", 32'(bus.byte_valid), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("t1_pulse_end",  32'(bus.out_valid),  32'h0);

        // d = 7, s = -2: shift only
        doReset();
        applyStimulus(16'h0100, 24'h000400);
        checkOutput("t2_out_range",  32'(bus.out_range),  32'h8000);
        checkOutput("t2_out_low",    32'(bus.out_low),    32'h020000);
        checkOutput("t2_cnt",        cnt_val(),           32'h1E);
        checkOutput("t2_byte_valid", 32'(bus.byte_valid), 32'h0);

        // d = 4, s = 2: one byte
        applyStimulus(16'h0800, 24'h123456);
        checkOutput("t3_byte_valid", 32'(bus.byte_valid), 32'h1);
        checkOutput("t3_byte_out",   32'(bus.byte_out),   32'h0048);
        checkOutput("t3_out_low",    32'(bus.out_low),    32'h034560);
        checkOutput("t3_out_range",  32'(bus.out_range),  32'h8000);
        checkOutput("t3_cnt",        cnt_val(),           32'h1A);
        bus.byte_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.byte_ready = 1'b0;
        checkOutput("t3_popped", 32'(bus.byte_valid), 32'h0);

        // range = 0x0080 then range = 0x0001: two bytes
        doReset();
        applyStimulus(16'h0080, 24'h000000);
        checkOutput("t4a_cnt",       cnt_val(),           32'h1F);
        checkOutput("t4a_byte_valid", 32'(bus.byte_valid), 32'h0);
        applyStimulus(16'h0001, 24'hABCDEF);
        checkOutput("t4_out_range",  32'(bus.out_range),  32'h8000);
        checkOutput("t4_out_low",    32'(bus.out_low),    32'h378000);
        checkOutput("t4_cnt",        cnt_val(),           32'h1E);
        checkOutput("t4_byte0",      32'(bus.byte_out),   32'h0157);
        checkOutput("t4_in_ready",   32'(bus.in_ready),   32'h1);
        bus.byte_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t4_byte1",      32'(bus.byte_out),   32'h009B);
        @(posedge clk);
        #1;
        bus.byte_ready = 1'b0;
        checkOutput("t4_empty",      32'(bus.byte_valid), 32'h0);

        // Fill the FIFO with two two-byte transactions, then drain it
        doReset();
        applyStimulus(16'h0080, 24'h000000);
        applyStimulus(16'h0001, 24'hABCDEF);
        checkOutput("t5a_in_ready",  32'(bus.in_ready),   32'h1);
        applyStimulus(16'h0020, 24'h5A5A5A);
        checkOutput("t5_out_low",    32'(bus.out_low),    32'h006800);
        checkOutput("t5_out_range",  32'(bus.out_range),  32'h8000);
        checkOutput("t5_cnt",        cnt_val(),           32'h18);
        checkOutput("t5_in_ready",   32'(bus.in_ready),   32'h0);

        // Input offered while not ready must be ignored
        applyStimulus(16'h0001, 24'hFFFFFF);
        checkOutput("t6_out_valid",  32'(bus.out_valid),  32'h0);
        checkOutput("t6_cnt",        cnt_val(),           32'h18);
        checkOutput("t6_out_low",    32'(bus.out_low),    32'h006800);
        checkOutput("t6_in_ready",   32'(bus.in_ready),   32'h0);

        drain_exp[0] = 16'h0157;
        drain_exp[1] = 16'h009B;
        drain_exp[2] = 16'h0169;
        drain_exp[3] = 16'h0069;
        bus.byte_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain%0d_valid", i), 32'(bus.byte_valid), 32'h1);
            checkOutput($sformatf("drain%0d_byte", i),  32'(bus.byte_out),   32'(drain_exp[i]));
            checkOutput($sformatf("drain%0d_ready", i), 32'(bus.in_ready),   (i >= 2) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
        end
        bus.byte_ready = 1'b0;
        checkOutput("drain_empty",   32'(bus.byte_valid), 32'h0);
        checkOutput("drain_ready",   32'(bus.in_ready),   32'h1);
`ifdef STAGE_3_BYTE_COUNT_EN
        checkOutput("drain_count",   byte_count,          32'd4);
`endif

        // Asynchronous reset with three bytes queued
        doReset();
        applyStimulus(16'h0080, 24'h000000);
        applyStimulus(16'h0001, 24'hABCDEF);
        applyStimulus(16'h0800, 24'h123456);
        checkOutput("t7_byte_valid", 32'(bus.byte_valid), 32'h1);
        checkOutput("t7_in_ready",   32'(bus.in_ready),   32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t7_rst_valid",  32'(bus.byte_valid), 32'h0);
        checkOutput("t7_rst_cnt",    cnt_val(),           32'h17);
        checkOutput("t7_rst_ready",  32'(bus.in_ready),   32'h1);
        checkOutput("t7_rst_byte",   32'(bus.byte_out),   32'h0);
`ifdef STAGE_3_BYTE_COUNT_EN
        checkOutput("t7_rst_count",  byte_count,          32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
